// File: rtl/spart_pkg.sv
// Shared constants for the SPART serial port: register addresses,
// FSM state encodings and oversampling figures.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    localparam int OVERSAMPLE = 16;

    // Enable count that closes a full bit, and the one marking mid-bit.
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud-rate down-counter: emits a one-cycle enable every divisor+1 clocks.
// A reload request restarts the count from the supplied divisor at once.
module spart_baud_gen #(
    parameter logic [15:0] RESET_DIV = 16'd1301
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        reload,
    output logic        enable
);

    logic [15:0] cnt_r;

    // Count down, reload on zero or on request, pulse enable on zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= RESET_DIV;
            enable <= 1'b0;
        end else if (reload) begin
            cnt_r  <= divisor;
            enable <= 1'b0;
        end else if (cnt_r == 16'd0) begin
            cnt_r  <= divisor;
            enable <= 1'b1;
        end else begin
            cnt_r  <= cnt_r - 16'd1;
            enable <= 1'b0;
        end
    end

endmodule

// File: rtl/spart.sv
// SPART: bus-mapped 8N1 UART with programmable divisor and 16x oversampling.
// TX and RX run independently off a shared baud enable.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIV = 16'd1301
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        rd_s, wr_s, rd_data_s, tx_accept_s, div_hi_wr_s, div_lo_wr_s, en_s;
    logic [7:0]  rd_mux_s, wdata_s;
    logic [15:0] div_r, div_next_s;

    tx_state_t   tx_state_r;
    logic [3:0]  tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_buf_r, tx_shift_r;
    logic        tbr_r, txd_r;

    rx_state_t   rx_state_r;
    logic [3:0]  rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_buf_r, rx_shift_r;
    logic        rda_r, rx_s1_r, rx_s2_r, rx_prev_r;

    assign rd_s        = iocs & iorw;
    assign wr_s        = iocs & ~iorw;
    assign wdata_s     = databus;
    assign rd_data_s   = rd_s & (ioaddr == ADDR_DATA);
    assign tx_accept_s = wr_s & (ioaddr == ADDR_DATA) & tbr_r;
    assign div_lo_wr_s = wr_s & (ioaddr == ADDR_DIV_LO);
    assign div_hi_wr_s = wr_s & (ioaddr == ADDR_DIV_HI);

    assign databus = rd_s ? rd_mux_s : 8'hzz;
    assign rda     = rda_r;
    assign tbr     = tbr_r;
    assign txd     = txd_r;

    // Read data mux; the rx buffer is returned as it stood before this edge.
    always_comb begin
        rd_mux_s = 8'h00;
        case (ioaddr)
            ADDR_DATA:   rd_mux_s = rx_buf_r;
            ADDR_STATUS: rd_mux_s = {6'b000000, tbr_r, rda_r};
            ADDR_DIV_LO: rd_mux_s = div_r[7:0];
            ADDR_DIV_HI: rd_mux_s = div_r[15:8];
            default:     rd_mux_s = 8'h00;
        endcase
    end

    // Next divisor value; the high-byte write also restarts the baud counter.
    always_comb begin
        div_next_s = div_r;
        if (div_hi_wr_s) begin
            div_next_s = {wdata_s, div_r[7:0]};
        end else if (div_lo_wr_s) begin
            div_next_s = {div_r[15:8], wdata_s};
        end else begin
            div_next_s = div_r;
        end
    end

    // Divisor register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= RESET_DIV;
        end else begin
            div_r <= div_next_s;
        end
    end

    spart_baud_gen #(.RESET_DIV(RESET_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor (div_next_s),
        .reload  (div_hi_wr_s),
        .enable  (en_s)
    );

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit; txd registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_buf_r   <= 8'h00;
            tx_shift_r <= 8'h00;
            tbr_r      <= 1'b1;
            txd_r      <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    txd_r <= 1'b1;
                    if (tx_accept_s) begin
                        tx_buf_r   <= wdata_s;
                        tbr_r      <= 1'b0;
                        txd_r      <= 1'b0;
                        tx_cnt_r   <= 4'd0;
                        tx_bit_r   <= 3'd0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (en_s) begin
                        if (tx_cnt_r == LAST_TICK) begin
                            tx_cnt_r   <= 4'd0;
                            tx_shift_r <= tx_buf_r;
                            txd_r      <= tx_buf_r[0];
                            tx_state_r <= TX_DATA;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (en_s) begin
                        if (tx_cnt_r == LAST_TICK) begin
                            tx_cnt_r <= 4'd0;
                            if (tx_bit_r == 3'd7) begin
                                txd_r      <= 1'b1;
                                tx_state_r <= TX_STOP;
                            end else begin
                                tx_bit_r   <= tx_bit_r + 3'd1;
                                tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                                txd_r      <= tx_shift_r[1];
                            end
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (en_s) begin
                        if (tx_cnt_r == LAST_TICK) begin
                            tx_cnt_r   <= 4'd0;
                            tbr_r      <= 1'b1;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    txd_r      <= 1'b1;
                    tbr_r      <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer for rxd plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_r   <= 1'b1;
            rx_s2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_s1_r   <= rxd;
            rx_s2_r   <= rx_s1_r;
            rx_prev_r <= rx_s2_r;
        end
    end

    // Receive FSM; a completing byte overrides a same-cycle data read clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_buf_r   <= 8'h00;
            rda_r      <= 1'b0;
        end else begin
            if (rd_data_s) begin
                rda_r <= 1'b0;
            end
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_s2_r) begin
                        rx_cnt_r   <= 4'd0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (en_s) begin
                        if (rx_cnt_r == MID_TICK) begin
                            rx_cnt_r   <= 4'd0;
                            rx_bit_r   <= 3'd0;
                            rx_state_r <= rx_s2_r ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (en_s) begin
                        if (rx_cnt_r == LAST_TICK) begin
                            rx_cnt_r   <= 4'd0;
                            rx_shift_r <= {rx_s2_r, rx_shift_r[7:1]};
                            if (rx_bit_r == 3'd7) begin
                                rx_state_r <= RX_STOP;
                            end else begin
                                rx_bit_r <= rx_bit_r + 3'd1;
                            end
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (en_s) begin
                        if (rx_cnt_r == LAST_TICK) begin
                            rx_cnt_r   <= 4'd0;
                            rx_state_r <= RX_IDLE;
                            if (rx_s2_r) begin
                                rx_buf_r <= rx_shift_r;
                                rda_r    <= 1'b1;
                            end
                        end else begin
                            rx_cnt_r <= rx_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spart.md
SPART -- requirements
Module: spart

Interface
REQ-001 The module SHALL have parameter RESET_DIV, default 16'd1301, meaning the baud divisor value loaded at reset (4800 baud at 100 MHz, 16x oversampling).
REQ-002 The module SHALL have port clk, input, 1, the single 100 MHz clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The module SHALL have port iocs, input, 1, chip select; every cycle with iocs=1 is one bus access.
REQ-005 The module SHALL have port iorw, input, 1, bus direction; 1 = read, 0 = write.
REQ-006 The module SHALL have port ioaddr, input, 2, register select; 00 = data, 01 = status, 10 = divisor low byte, 11 = divisor high byte.
REQ-007 The module SHALL have port databus, inout, 8, data bus; driven only when iocs=1 and iorw=1, otherwise 8'hZZ.
REQ-008 The module SHALL have port rda, output, 1, receive data available.
REQ-009 The module SHALL have port tbr, output, 1, transmit buffer ready.
REQ-010 The module SHALL have port txd, output, 1, serial out; idles high.
REQ-011 The module SHALL have port rxd, input, 1, serial in; asynchronous; idles high.

Function
REQ-012 Register map:
- Read 00 SHALL return the rx buffer and clear rda at the end of the cycle; the rx buffer SHALL hold its value across repeated reads until a new byte is received.
- Write 00 with tbr=1 SHALL load the tx buffer and deassert tbr on the next cycle.
- Write 00 with tbr=0 SHALL be ignored.
- Read 01 SHALL return {6'b0, tbr, rda} with no side effects.
- Write 10 / 11 SHALL load divisor[7:0] / divisor[15:8].
- Read 10 / 11 SHALL return the matching divisor byte.
- Write 01 SHALL be ignored.
REQ-013 Baud generator: a down-counter SHALL reload from divisor at zero, and SHALL pulse a one-cycle enable at zero, so enable period = divisor+1 clocks.
REQ-014 A write to 11 SHALL reload the counter immediately. A write to 10 alone SHALL take effect at the next reload.
REQ-015 One bit time SHALL be 16 enables.
REQ-016 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-017 TX FSM: states IDLE, START, DATA, STOP.
- IDLE->START on an accepted write.
- START->DATA after 16 enables.
- DATA->STOP after the 8th bit has lasted 16 enables.
- STOP->IDLE after 16 enables; tbr SHALL rise in the same cycle.
- txd SHALL be registered.
REQ-018 rxd SHALL pass through a 2-flop synchronizer before use.
REQ-019 RX FSM: states IDLE, START, DATA, STOP.
- IDLE->START on a synchronized falling edge.
- START samples at the 8th enable: if the sample is 1 it is a false start and the FSM SHALL return to IDLE; if 0 it SHALL go to DATA.
- DATA samples every 16 enables, 8 times, shifting LSB first.
- STOP samples once after 16 more enables.
REQ-020 A stop bit sampled as 1 SHALL load the rx buffer and set rda in the same cycle. A stop bit sampled as 0 (framing error) SHALL discard the byte and leave rda and the buffer unchanged; the FSM SHALL return to IDLE in both cases.
REQ-021 A new byte completing while rda=1 SHALL overwrite the buffer; rda stays 1.
REQ-022 If a 00 read and a byte completion fall in the same cycle, the read SHALL return the old byte and rda SHALL end the cycle set.
REQ-023 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-024 On rst=1 at a clock edge, the module SHALL reach this state:
- tbr=1, rda=0, txd=1
- divisor=RESET_DIV, baud counter=RESET_DIV
- both FSMs in IDLE
- rx/tx buffers and shift registers = 8'h00
- synchronizer flops = 1
- databus released
REQ-025 Reset asserted mid-frame SHALL abort the frame; txd SHALL be 1 the cycle after the reset edge.

Structure
REQ-026 Package spart_pkg SHALL hold the address constants (ADDR_DATA, ADDR_STATUS, ADDR_DIV_LO, ADDR_DIV_HI), the TX/RX state encodings, and OVERSAMPLE=16.
REQ-027 The baud down-counter SHALL be a sub-module named spart_baud_gen (inputs: divisor, reload; output: enable). TX and RX logic SHALL stay in spart.

Verification
REQ-028 Reset, then read 01 -> databus=8'h02; txd=1.
REQ-029 Write 10 = 8'h04, 11 = 8'h00, then write 00 = 8'hA5:
- tbr=0 the next cycle
- txd shows 0,1,0,1,0,0,1,0,1,1, each bit 80 clocks
- tbr=1 at the end of the stop bit.
REQ-030 With divisor=4, drive rxd with a frame of 8'h3C at 80 clocks/bit:
- rda=1 within the stop bit
- read 00 returns 8'h3C and rda=0 next cycle
- a second read returns 8'h3C.
REQ-031 With divisor=4:
- rxd low pulse of 30 clocks -> no rda (false start)
- frame 8'h55 with stop bit 0 -> no rda (framing error).
REQ-032 Write 00 = 8'h11 then 00 = 8'h22 while tbr=0 -> only 8'h11 is transmitted.
REQ-033 Assert rst in the middle of a TX frame and mid-RX -> txd=1, tbr=1, rda=0 the next cycle; a subsequent 8'h81 loopback (txd wired to rxd) is received correctly.
